// File: rtl/fp_divider_pkg.sv
// Shared binary32 constants, FSM state codes and operand classification for the FP divider.
package fp_divider_pkg;

    localparam logic [31:0] ZERO                     = 32'h0000_0000;
    localparam logic [31:0] INFINITY_POSITIVE_CONST  = 32'h7F80_0000;
    localparam logic [31:0] INFINITY_NEGATIVE_CONST  = 32'hFF80_0000;
    localparam logic [31:0] QNAN_SAMPLE_CONST        = 32'h7FC0_0000;
    localparam logic [31:0] SNAN_CONST               = 32'b?_11111111_0??????_????????_????????;
    localparam logic [31:0] QNAN_CONST               = 32'b?_11111111_1??????_????????_????????;
    localparam logic [31:0] INFINITY_GENERAL_PATTERN = 32'b?_11111111_0000000_00000000_00000000;

    localparam int unsigned EXP_BIAS    = 127;
    localparam int unsigned FP_DIV_ITER = 25;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_SPECIAL   = 2'd1;
    localparam logic [1:0] ST_DIVIDE    = 2'd2;
    localparam logic [1:0] ST_NORMALIZE = 2'd3;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Exponent-0 nonzero values are not flagged: they divide as normals with a hidden 1.
    function automatic fp_class_t classify(input logic [31:0] x);
        fp_class_t c;
        c.nan  = ((x ==? SNAN_CONST) && (x[22:0] != 23'd0)) || (x ==? QNAN_CONST);
        c.inf  = (x ==? INFINITY_GENERAL_PATTERN);
        c.zero = (x[30:0] == ZERO[30:0]);
        return c;
    endfunction

endpackage

// File: rtl/fp_div_mantissa_core.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
module fp_div_mantissa_core
    import fp_divider_pkg::*;
#(
    parameter int unsigned ITER = FP_DIV_ITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [22:0]     frac_a,
    input  logic [22:0]     frac_b,
    output logic [ITER-1:0] q,
    output logic            last,
    output logic            valid
);

    localparam int unsigned CW = $clog2(ITER + 1);

    logic [25:0]   rem;
    logic [23:0]   dvs;
    logic [CW-1:0] cnt;
    logic          ge;
    logic [25:0]   sel;

    always_comb begin
        ge  = rem >= {2'b00, dvs};
        sel = ge ? (rem - {2'b00, dvs}) : rem;
    end

    assign last  = (cnt == CW'(ITER - 1));
    assign valid = (cnt == CW'(ITER));

    // Remainder stays below 2*divisor, so the shift never loses a set bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
            dvs <= '0;
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= {3'b001, frac_a};
            dvs <= {1'b1, frac_b};
            q   <= '0;
            cnt <= '0;
        end else if (step && !valid) begin
            q   <= {q[ITER-2:0], ge};
            rem <= sel << 1;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Iterative binary32 divider (a / b), truncating, with start/busy/done handshake.
module fp_divider
    import fp_divider_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow,
    output logic        underflow,
    output logic        divide_by_zero
);

    logic [1:0]               state;
    logic [31:0]              op_a;
    logic [31:0]              op_b;
    fp_class_t                in_a, in_b, ca, cb;
    logic                     accept;
    logic                     in_special;
    logic                     sign;
    logic [31:0]              sp_result;
    logic                     sp_dbz;
    logic signed [9:0]        e;
    logic [22:0]              mant;
    logic                     core_last;
    logic                     core_valid;
    logic [FP_DIV_ITER-1:0]   q;

    fp_div_mantissa_core #(.ITER(FP_DIV_ITER)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state == ST_DIVIDE),
        .frac_a (a[22:0]),
        .frac_b (b[22:0]),
        .q      (q),
        .last   (core_last),
        .valid  (core_valid)
    );

    always_comb begin
        in_a       = classify(a);
        in_b       = classify(b);
        ca         = classify(op_a);
        cb         = classify(op_b);
        accept     = start && (state == ST_IDLE) && !done;
        in_special = (|in_a) || (|in_b);
        sign       = op_a[31] ^ op_b[31];
    end

    // Priority order matters: inf/0 must yield infinity without divide_by_zero.
    always_comb begin
        sp_dbz = 1'b0;
        if (ca.nan || cb.nan || (ca.zero && cb.zero) || (ca.inf && cb.inf))
            sp_result = QNAN_SAMPLE_CONST;
        else if (ca.inf)
            sp_result = sign ? INFINITY_NEGATIVE_CONST : INFINITY_POSITIVE_CONST;
        else if (cb.zero) begin
            sp_result = sign ? INFINITY_NEGATIVE_CONST : INFINITY_POSITIVE_CONST;
            sp_dbz    = 1'b1;
        end else
            sp_result = {sign, 31'd0};
    end

    always_comb begin
        e = $signed({2'b00, op_a[30:23]} - {2'b00, op_b[30:23]}
                    + (q[24] ? 10'(EXP_BIAS) : 10'(EXP_BIAS - 1)));
        mant = q[24] ? q[23:1] : q[22:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            op_a           <= '0;
            op_b           <= '0;
            result         <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            divide_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        op_a           <= a;
                        op_b           <= b;
                        busy           <= 1'b1;
                        overflow       <= 1'b0;
                        underflow      <= 1'b0;
                        divide_by_zero <= 1'b0;
                        state          <= in_special ? ST_SPECIAL : ST_DIVIDE;
                    end
                end
                ST_SPECIAL: begin
                    result         <= sp_result;
                    divide_by_zero <= sp_dbz;
                    done           <= 1'b1;
                    state          <= ST_IDLE;
                end
                ST_DIVIDE: begin
                    if (core_last)
                        state <= ST_NORMALIZE;
                end
                ST_NORMALIZE: begin
                    if (core_valid) begin
                        if (e >= 10'sd255) begin
                            result   <= sign ? INFINITY_NEGATIVE_CONST : INFINITY_POSITIVE_CONST;
                            overflow <= 1'b1;
                        end else if (e <= 10'sd0) begin
                            result    <= {sign, 31'd0};
                            underflow <= 1'b1;
                        end else
                            result <= {sign, e[7:0], mant};
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
